frac_deci_sched: RTL

Polyphase MAC scheduler for the L/M fractional decimator in the DFE filter chain (default 2/3, 9 MHz in → 6 MHz out). It tracks the rational phase, decides when enough input samples have arrived for the next output, and sequences one shared multiplier-accumulator over the taps of the selected polyphase branch. It drives circular delay-line write/read addresses, the coefficient ROM address, accumulator controls and the output strobe. It holds no sample data.

---
 rtl/frac_deci_sched.sv | 127 ++++++++++++
 1 files changed

// File: rtl/frac_deci_sched.sv
// Polyphase MAC scheduler for an L/M fractional decimator: tracks the rational
// phase, decides when each output can start and sequences one shared MAC over its taps.
module frac_deci_sched #(
  parameter  int L          = 2,
  parameter  int M          = 3,
  parameter  int PHASE_TAPS = 57,
  parameter  int ADDR_W     = 7,
  parameter  int CADDR_W    = 7,
  parameter  int MAC_LAT    = 2,
  localparam int PH_W       = (L > 1) ? $clog2(L) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [CADDR_W-1:0] coef_addr,
  output logic               mac_en,
  output logic               mac_clr,
  output logic               out_valid,
  output logic [PH_W-1:0]    phase,
  output logic               busy,
  output logic               overrun
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CAP    = DEPTH - PHASE_TAPS;
  localparam int PEND_W = $clog2(DEPTH + 1);
  localparam int K_W    = (PHASE_TAPS > 1) ? $clog2(PHASE_TAPS) : 1;
  localparam int D_W    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam int S_W    = $clog2(L + M) + 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr, cons_ptr, base;
  logic [PEND_W-1:0]   pending, need, pending_d, consume;
  logic [PH_W-1:0]     p;
  logic [K_W-1:0]      k;
  logic [D_W-1:0]      dcnt;
  logic [S_W-1:0]      p_sum;
  logic                overrun_q, start, inc;

  assign wr_en   = in_valid;
  assign wr_addr = wr_ptr;
  assign phase   = p;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

  // Start test sees only the registered count; a same-cycle write lands in pending_d.
  assign start     = (state_q == IDLE) && (pending >= need);
  assign inc       = in_valid && (pending != PEND_W'(CAP));
  assign consume   = start ? need : '0;
  assign pending_d = pending - consume + PEND_W'(inc);
  assign p_sum     = S_W'(p) + S_W'(M);

  always_comb begin
    state_d   = state_q;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    rd_addr   = '0;
    coef_addr = '0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = COMPUTE;
      end
      COMPUTE: begin
        mac_en    = 1'b1;
        mac_clr   = (k == '0);
        rd_addr   = base - ADDR_W'(k);
        coef_addr = CADDR_W'(p) * CADDR_W'(PHASE_TAPS) + CADDR_W'(k);
        if (k == K_W'(PHASE_TAPS - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (dcnt == D_W'(MAC_LAT - 1)) begin
          out_valid = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr    <= '0;
      cons_ptr  <= '0;
      base      <= '0;
      pending   <= '0;
      need      <= PEND_W'(1);
      p         <= '0;
      k         <= '0;
      dcnt      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending <= pending_d;
      if (in_valid) wr_ptr <= wr_ptr + 1'b1;
      if (in_valid && pending == PEND_W'(CAP)) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            base     <= cons_ptr + ADDR_W'(need) - 1'b1;
            cons_ptr <= cons_ptr + ADDR_W'(need);
            k        <= '0;
          end
        end
        COMPUTE: begin
          k    <= k + 1'b1;
          dcnt <= '0;
        end
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (out_valid) begin
            need <= PEND_W'(p_sum / S_W'(L));
            p    <= PH_W'(p_sum % S_W'(L));
          end
        end
        default: ;
      endcase
    end
  end

endmodule
